// File: rtl/pudp_pkg.sv
// Shared PUDP frame constants, FSM state type and tkeep helpers.
// Imported by both the receive decoder and the transmit encoder.
package pudp_pkg;

    localparam int PUDP_NUM_CH = 4;
    localparam int PUDP_LANES  = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TYPE = 3'd1,
        LOAD = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4
    } pudp_state_t;

    // Lanes 0 up to (but not including) the first cleared tkeep bit.
    function automatic logic [PUDP_LANES-1:0] keep_contig(input logic [PUDP_LANES-1:0] keep);
        logic [PUDP_LANES-1:0] mask;
        logic                  run;
        mask = '0;
        run  = 1'b1;
        for (int i = 0; i < PUDP_LANES; i++) begin
            run     = run & keep[i];
            mask[i] = run;
        end
        return mask;
    endfunction

    function automatic logic keep_violation(input logic [PUDP_LANES-1:0] keep);
        return (keep & ~keep_contig(keep)) != '0;
    endfunction

endpackage

// File: rtl/pudp_rr_arb.sv
// Round-robin channel picker: combinational search from last_grant+1, 0-cycle latency.
// last_grant only advances on the frame-done strobe, so a held grant never rotates mid-frame.
module pudp_rr_arb
    import pudp_pkg::*;
#(
    parameter int NUM_CH = PUDP_NUM_CH,
    parameter int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              done,
    input  logic [GW-1:0]     done_grant,
    output logic [GW-1:0]     gnt_bin,
    output logic              gnt_vld
);

    logic [GW-1:0] last_grant;
    logic [GW-1:0] cand;

    // Walk from farthest to nearest so the closest requester after last_grant wins.
    always_comb begin
        gnt_bin = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = GW'((int'(last_grant) + i) % NUM_CH);
            if (req[cand]) begin
                gnt_bin = cand;
                gnt_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GW'(NUM_CH - 1);
        end else if (done) begin
            last_grant <= done_grant;
        end
    end

endmodule

// File: rtl/pudp_encode.sv
// PUDP frame encoder: arbitrates 64-bit AXIS channels into 8-bit {type, payload, xor} frames.
// Serialises one byte per accepted m_axis handshake; input beats are only taken in LOAD, one per cycle.
module pudp_encode
    import pudp_pkg::*;
#(
    parameter int NUM_CH = PUDP_NUM_CH,
    parameter int DATA_W = 64
) (
    input  logic                             clki,
    input  logic                             rsti,
    input  logic [NUM_CH-1:0]                s_axis_tvalid,
    output logic [NUM_CH-1:0]                s_axis_tready,
    input  logic [NUM_CH-1:0]                s_axis_tlast,
    input  logic [NUM_CH-1:0][DATA_W/8-1:0]  s_axis_tkeep,
    input  logic [NUM_CH-1:0][DATA_W-1:0]    s_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [7:0]                       m_axis_tdata,
    output logic                             m_axis_tlast,
    output logic                             keep_err,
    output logic [31:0]                      frame_cnt
);

    localparam int LANES = DATA_W / 8;
    localparam int GW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    pudp_state_t       state;
    logic [GW-1:0]     grant;
    logic [7:0]        csum;
    logic [DATA_W-1:0] byte_buf;
    logic [LANES-1:0]  keep_q;
    logic              last_q;

    logic [GW-1:0]     arb_bin;
    logic              arb_vld;
    logic              frame_done;
    logic [LANES-1:0]  beat_keep;

    assign frame_done = (state == CSUM) && m_axis_tready;
    assign beat_keep  = keep_contig(s_axis_tkeep[grant]);

    pudp_rr_arb #(
        .NUM_CH (NUM_CH),
        .GW     (GW)
    ) u_arb (
        .clk        (clki),
        .rst        (rsti),
        .req        (s_axis_tvalid),
        .done       (frame_done),
        .done_grant (grant),
        .gnt_bin    (arb_bin),
        .gnt_vld    (arb_vld)
    );

    always_ff @(posedge clki) begin
        if (rsti) begin
            state     <= IDLE;
            grant     <= '0;
            csum      <= '0;
            byte_buf  <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            keep_err  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            keep_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_vld) begin
                        grant <= arb_bin;
                        csum  <= 8'(arb_bin);
                        state <= TYPE;
                    end
                end
                TYPE: begin
                    if (m_axis_tready) state <= LOAD;
                end
                LOAD: begin
                    if (s_axis_tvalid[grant]) begin
                        byte_buf <= s_axis_tdata[grant];
                        keep_q   <= beat_keep;
                        last_q   <= s_axis_tlast[grant];
                        keep_err <= keep_violation(s_axis_tkeep[grant]);
                        // An all-zero non-last beat is swallowed and we wait for the next one.
                        if (beat_keep != '0) begin
                            state <= DATA;
                        end else if (s_axis_tlast[grant]) begin
                            state <= CSUM;
                        end
                    end
                end
                DATA: begin
                    if (m_axis_tready) begin
                        csum     <= csum ^ byte_buf[7:0];
                        byte_buf <= byte_buf >> 8;
                        keep_q   <= keep_q >> 1;
                        if (keep_q[LANES-1:1] == '0) begin
                            state <= last_q ? CSUM : LOAD;
                        end
                    end
                end
                CSUM: begin
                    if (m_axis_tready) begin
                        frame_cnt <= frame_cnt + 32'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by rsti so the bus is quiet from the first reset cycle, not one edge later.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        s_axis_tready = '0;
        if (!rsti) begin
            case (state)
                TYPE: begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = 8'(grant);
                end
                LOAD: s_axis_tready = NUM_CH'(1) << grant;
                DATA: begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = byte_buf[7:0];
                end
                CSUM: begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = csum;
                    m_axis_tlast  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pudp_encode.sv
// Bench for pudp_encode: per-channel beat queues feed the DUT, output bytes are collected and
// compared with frames built from the framing rules (contiguous keep, xor checksum, round-robin).
module tb_pudp_encode;
    import pudp_pkg::*;

    localparam int NCH = PUDP_NUM_CH;

    logic                     clki = 1'b0;
    logic                     rsti;
    logic [NCH-1:0]           s_tvalid, s_tready, s_tlast;
    logic [NCH-1:0][7:0]      s_tkeep;
    logic [NCH-1:0][63:0]     s_tdata;
    logic                     m_tvalid, m_tready, m_tlast, keep_err;
    logic [7:0]               m_tdata;
    logic [31:0]              frame_cnt;

    always #5 clki = ~clki;

    pudp_encode #(.NUM_CH(NCH), .DATA_W(64)) dut (
        .clki          (clki),
        .rsti          (rsti),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .keep_err      (keep_err),
        .frame_cnt     (frame_cnt)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    beat_t      src [NCH][$];
    beat_t      rrp [NCH][$];
    logic [8:0] rx[$];
    logic [8:0] exp_q[$];
    logic [8:0] ref_q[$];
    int n_chk = 0, n_fail = 0;
    int stall_err = 0, kerr_cnt = 0;
    int exp_frames = 0;
    int mdl_last = NCH - 1;
    bit rand_rdy = 1'b0;

    // Source driver and output monitor; everything sampled on the falling edge.
    initial begin : drv
        logic [NCH-1:0] hs;
        logic           o_hs;
        logic [8:0]     o_byte;
        logic           stall_q;
        logic [7:0]     stall_dat;
        stall_q = 1'b0; stall_dat = '0;
        s_tvalid = '0; s_tlast = '0; s_tkeep = '0; s_tdata = '0; m_tready = 1'b1;
        forever begin
            @(negedge clki);
            hs     = s_tvalid & s_tready;
            o_hs   = m_tvalid & m_tready;
            o_byte = {m_tlast, m_tdata};
            if (keep_err === 1'b1) kerr_cnt++;
            if (stall_q && !rsti && (m_tvalid !== 1'b1 || m_tdata !== stall_dat)) stall_err++;
            stall_q   = m_tvalid & ~m_tready & ~rsti;
            stall_dat = m_tdata;
            @(posedge clki);
            #1;
            for (int c = 0; c < NCH; c++) begin
                if (hs[c] && src[c].size() > 0) src[c].delete(0);
                if (src[c].size() > 0) begin
                    s_tvalid[c] = 1'b1;
                    s_tdata[c]  = src[c][0].data;
                    s_tkeep[c]  = src[c][0].keep;
                    s_tlast[c]  = src[c][0].last;
                end else begin
                    s_tvalid[c] = 1'b0;
                    s_tdata[c]  = '0;
                    s_tkeep[c]  = '0;
                    s_tlast[c]  = 1'b0;
                end
            end
            if (o_hs) rx.push_back(o_byte);
            m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, test incomplete");
        $fatal(1, "watchdog");
    end

    // Reference frame: type, bytes of lanes below the first cleared keep bit, then xor of all.
    function automatic void add_frame(input int ch, input beat_t b[$]);
        logic [7:0] cs;
        cs = 8'(ch);
        exp_q.push_back({1'b0, 8'(ch)});
        foreach (b[i]) begin
            for (int l = 0; l < 8; l++) begin
                if (!b[i].keep[l]) break;
                exp_q.push_back({1'b0, b[i].data[l*8 +: 8]});
                cs ^= b[i].data[l*8 +: 8];
            end
        end
        exp_q.push_back({1'b1, cs});
        mdl_last = ch;
        exp_frames++;
    endfunction

    function automatic int rr_pick(input bit [NCH-1:0] pend);
        for (int i = 1; i <= NCH; i++) begin
            if (pend[(mdl_last + i) % NCH]) return (mdl_last + i) % NCH;
        end
        return -1;
    endfunction

    task automatic send(input int ch, input beat_t b[$]);
        foreach (b[i]) src[ch].push_back(b[i]);
    endtask

    task automatic wait_rx(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clki);
            if (rx.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(posedge clki);
        #2;
    endtask

    task automatic test_reset();
        beat_t b;
        rsti = 1'b1;
        b.data = 64'h55; b.keep = 8'h01; b.last = 1'b1;
        src[0].push_back(b);
        repeat (4) @(posedge clki);
        @(negedge clki);
        n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
        n_chk++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
        n_chk++; if (m_tdata !== 8'h00) begin n_fail++; $display("FAIL reset_tdata: got %h want 00", m_tdata); end
        n_chk++; if (s_tready !== '0) begin n_fail++; $display("FAIL reset_tready: got %b want 0", s_tready); end
        n_chk++; if (keep_err !== 1'b0) begin n_fail++; $display("FAIL reset_keep_err: got %b want 0", keep_err); end
        n_chk++; if (frame_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        src[0].delete();
        @(posedge clki); #2;
        rsti = 1'b0;
        repeat (3) @(posedge clki); #2;
        n_chk++; if (rx.size() != 0) begin n_fail++; $display("FAIL reset_idle_out: got %0d bytes want 0", rx.size()); end
    endtask

    task automatic test_single_beat();
        beat_t p[$];
        bit ok;
        rx.delete(); exp_q.delete();
        p.push_back('{data: 64'h0000_0000_0033_2211, keep: 8'h07, last: 1'b1});
        add_frame(2, p);
        send(2, p);
        wait_rx(exp_q.size(), ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d bytes want %0d", rx.size(), exp_q.size()); end
        n_chk++; if (rx.size() != exp_q.size()) begin n_fail++; $display("FAIL single_len: got %0d want %0d", rx.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            n_chk++; if (rx[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h want %h", i, rx[i], exp_q[i]); end
        end
        n_chk++; if (frame_cnt !== 32'(exp_frames)) begin n_fail++; $display("FAIL single_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_two_beat();
        beat_t p[$];
        bit ok;
        rx.delete(); exp_q.delete();
        p.push_back('{data: 64'h0807_0605_0403_0201, keep: 8'hFF, last: 1'b0});
        p.push_back('{data: 64'h0000_0000_0000_0A09, keep: 8'h03, last: 1'b1});
        add_frame(0, p);
        send(0, p);
        wait_rx(exp_q.size(), ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL two_beat_timeout: got %0d bytes want %0d", rx.size(), exp_q.size()); end
        n_chk++; if (rx.size() != 12) begin n_fail++; $display("FAIL two_beat_len: got %0d want 12", rx.size()); end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            n_chk++; if (rx[i] !== exp_q[i]) begin n_fail++; $display("FAIL two_beat_byte%0d: got %h want %h", i, rx[i], exp_q[i]); end
        end
        n_chk++; if (frame_cnt !== 32'(exp_frames)) begin n_fail++; $display("FAIL two_beat_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_round_robin();
        int chs[3] = '{0, 1, 3};
        bit [NCH-1:0] pend;
        beat_t p[$];
        beat_t b;
        bit ok;
        int c;
        rx.delete(); exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            foreach (chs[j]) begin
                b.data = {$urandom, $urandom}; b.keep = 8'h01; b.last = 1'b1;
                rrp[chs[j]].push_back(b);
                src[chs[j]].push_back(b);
            end
        end
        for (int f = 0; f < 6; f++) begin
            pend = '0;
            for (int q = 0; q < NCH; q++) pend[q] = (rrp[q].size() > 0);
            c = rr_pick(pend);
            p.delete();
            p.push_back(rrp[c].pop_front());
            add_frame(c, p);
        end
        wait_rx(exp_q.size(), ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d bytes want %0d", rx.size(), exp_q.size()); end
        n_chk++; if (rx.size() != exp_q.size()) begin n_fail++; $display("FAIL rr_len: got %0d want %0d", rx.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            n_chk++; if (rx[i] !== exp_q[i]) begin n_fail++; $display("FAIL rr_byte%0d: got %h want %h", i, rx[i], exp_q[i]); end
        end
        n_chk++; if (frame_cnt !== 32'(exp_frames)) begin n_fail++; $display("FAIL rr_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_stall();
        beat_t p[$];
        bit ok;
        p.push_back('{data: {$urandom, $urandom}, keep: 8'hFF, last: 1'b0});
        p.push_back('{data: {$urandom, $urandom}, keep: 8'hFF, last: 1'b0});
        p.push_back('{data: {$urandom, $urandom}, keep: 8'h0F, last: 1'b1});
        rx.delete(); exp_q.delete();
        rand_rdy = 1'b0;
        add_frame(1, p);
        send(1, p);
        wait_rx(exp_q.size(), ok);
        n_chk++; if (rx.size() != 22) begin n_fail++; $display("FAIL stall_ref_len: got %0d want 22", rx.size()); end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            n_chk++; if (rx[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_ref_byte%0d: got %h want %h", i, rx[i], exp_q[i]); end
        end
        ref_q = rx;
        rx.delete(); exp_q.delete();
        stall_err = 0;
        rand_rdy = 1'b1;
        add_frame(1, p);
        send(1, p);
        wait_rx(ref_q.size(), ok);
        rand_rdy = 1'b0;
        n_chk++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: got %0d bytes want %0d", rx.size(), ref_q.size()); end
        n_chk++; if (rx.size() != ref_q.size()) begin n_fail++; $display("FAIL stall_len: got %0d want %0d", rx.size(), ref_q.size()); end
        for (int i = 0; i < ref_q.size() && i < rx.size(); i++) begin
            n_chk++; if (rx[i] !== ref_q[i]) begin n_fail++; $display("FAIL stall_byte%0d: got %h want %h", i, rx[i], ref_q[i]); end
        end
        n_chk++; if (stall_err != 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_err); end
        n_chk++; if (frame_cnt !== 32'(exp_frames)) begin n_fail++; $display("FAIL stall_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_keep_err();
        beat_t p[$];
        bit ok;
        int k0;
        rx.delete(); exp_q.delete();
        k0 = kerr_cnt;
        p.push_back('{data: 64'h0000_0000_DDEE_BBAA, keep: 8'h0B, last: 1'b1});
        add_frame(3, p);
        send(3, p);
        wait_rx(exp_q.size(), ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL keep_timeout: got %0d bytes want %0d", rx.size(), exp_q.size()); end
        n_chk++; if (rx.size() != 4) begin n_fail++; $display("FAIL keep_len: got %0d want 4", rx.size()); end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            n_chk++; if (rx[i] !== exp_q[i]) begin n_fail++; $display("FAIL keep_byte%0d: got %h want %h", i, rx[i], exp_q[i]); end
        end
        n_chk++; if (kerr_cnt - k0 != 1) begin n_fail++; $display("FAIL keep_err_pulses: got %0d want 1", kerr_cnt - k0); end
    endtask

    task automatic test_random();
        beat_t p[$];
        beat_t b;
        bit ok;
        int k0;
        k0 = kerr_cnt;
        rand_rdy = 1'b1;
        for (int n = 0; n < 8; n++) begin
            int ch;
            int nb;
            int nl;
            ch = $urandom_range(0, NCH - 1);
            nb = $urandom_range(1, 3);
            p.delete(); rx.delete(); exp_q.delete();
            for (int j = 0; j < nb; j++) begin
                nl = (n == 0) ? 0 : $urandom_range(0, 8);
                b.data = {$urandom, $urandom};
                b.keep = 8'((16'd1 << nl) - 16'd1);
                b.last = (j == nb - 1);
                p.push_back(b);
            end
            add_frame(ch, p);
            send(ch, p);
            wait_rx(exp_q.size(), ok);
            n_chk++; if (!ok) begin n_fail++; $display("FAIL rand%0d_timeout: got %0d bytes want %0d", n, rx.size(), exp_q.size()); end
            n_chk++; if (rx.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_len: got %0d want %0d", n, rx.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
                n_chk++; if (rx[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h want %h", n, i, rx[i], exp_q[i]); end
            end
        end
        rand_rdy = 1'b0;
        n_chk++; if (frame_cnt !== 32'(exp_frames)) begin n_fail++; $display("FAIL rand_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
        n_chk++; if (kerr_cnt != k0) begin n_fail++; $display("FAIL rand_keep_err: got %0d pulses want 0", kerr_cnt - k0); end
    endtask

    task automatic test_reset_mid_frame();
        beat_t p[$];
        bit ok;
        bit saw_last;
        rx.delete(); exp_q.delete();
        for (int j = 0; j < 3; j++) p.push_back('{data: {$urandom, $urandom}, keep: 8'hFF, last: (j == 2)});
        send(2, p);
        wait_rx(5, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL midrst_timeout: got %0d bytes want 5", rx.size()); end
        rsti = 1'b1;
        src[2].delete();
        repeat (3) @(posedge clki);
        @(negedge clki);
        saw_last = 1'b0;
        foreach (rx[i]) if (rx[i][8]) saw_last = 1'b1;
        n_chk++; if (saw_last) begin n_fail++; $display("FAIL midrst_no_tlast: got tlast=1 before reset want 0"); end
        n_chk++; if ({m_tvalid, m_tlast, m_tdata} !== 10'd0) begin n_fail++; $display("FAIL midrst_outputs: got %b want 0", {m_tvalid, m_tlast, m_tdata}); end
        n_chk++; if (s_tready !== '0) begin n_fail++; $display("FAIL midrst_tready: got %b want 0", s_tready); end
        n_chk++; if (frame_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_frame_cnt_rst: got %0d want 0", frame_cnt); end
        @(posedge clki); #2;
        rsti = 1'b0;
        mdl_last = NCH - 1;
        exp_frames = 0;
        rx.delete(); exp_q.delete(); p.delete();
        p.push_back('{data: {$urandom, $urandom}, keep: 8'h1F, last: 1'b1});
        add_frame(1, p);
        send(1, p);
        wait_rx(exp_q.size(), ok);
        n_chk++; if (rx.size() != exp_q.size()) begin n_fail++; $display("FAIL midrst_len: got %0d want %0d", rx.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            n_chk++; if (rx[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_byte%0d: got %h want %h", i, rx[i], exp_q[i]); end
        end
        n_chk++; if (frame_cnt !== 32'd1) begin n_fail++; $display("FAIL midrst_frame_cnt: got %0d want 1", frame_cnt); end
    endtask

    initial begin : main
        rsti = 1'b1;
        test_reset();
        test_single_beat();
        test_two_beat();
        test_round_robin();
        test_stall();
        test_keep_err();
        test_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
